ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the pipelined MIPS datapath, directly downstream of `ALU_Ctrl`. It consumes the 4-bit `Operation` code plus the ID/EX operands and produces a registered EX/MEM result with destination metadata. Single-cycle ALU ops complete in one cycle. `MUL` runs as an iterative 4-cycle multiply that back-pressures the issue stage. The stage also honours downstream stall and pipeline flush.

## Interface
Parameters:
- `WIDTH`, default 32, datapath width; `MUL` iteration count is `WIDTH/8`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  ID/EX beat present.
- `in_ready`  out  1  stage can accept a beat this cycle.
- `operation`  in  4  ALU code from `ALU_Ctrl`.
- `op_a`, `op_b`  in  WIDTH  rs/rt operand values.
- `shamt`  in  5  shift amount.
- `rd`  in  5  destination register.
- `reg_write`  in  1  writeback enable.
- `stall_in`  in  1  MEM stage cannot take a result; hold the EX/MEM register.
- `flush`  in  1  kill in-flight work (branch/exception).
- `out_valid`  out  1  EX/MEM register holds a valid result.
- `result`  out  WIDTH  ALU/MUL result.
- `zero`  out  1  `result == 0`.
- `out_rd`  out  5  registered `rd`.
- `out_reg_write`  out  1  registered `reg_write`.
- `busy`  out  1  `MUL` iteration in progress.

## Operation
- Op codes: `0000` AND, `0001` OR, `0010` ADD, `0110` SUB, `0111` SLT (signed, result 1/0), `1100` NOR, `0011` XOR, `0100` SLL `op_b<<shamt`, `0101` SRL logical, `1000` MUL (low WIDTH bits).
- Undefined codes produce `result = 0` and retire normally.
- ADD/SUB/MUL wrap modulo 2^WIDTH; no overflow flag.
- `in_ready = rst & (state==IDLE) & ~stall_in`. A beat is accepted when `in_valid & in_ready & ~flush`.
- FSM states:
  - `IDLE`: an accepted non-MUL beat loads the EX/MEM register at that edge and sets `out_valid=1`. An accepted MUL loads `a`, `b`, `rd`, `reg_write`, sets `acc = a*b[7:0]` and `cnt = 1`, then goes to `MUL`.
  - `MUL`: each edge adds `(a*b[8cnt+7:8cnt]) << 8cnt` and increments `cnt`. On the last slice (`cnt == WIDTH/8-1`) with `~stall_in`, the EX/MEM register is loaded, `out_valid=1`, and the FSM returns to `IDLE`. If `stall_in` is high on the last slice, the FSM holds in `MUL` without re-adding.
- No accept and `~stall_in`: `out_valid` goes to 0 (bubble). `result`, `out_rd` and `out_reg_write` keep their old values.
- `stall_in` high: the EX/MEM register holds all fields, including `out_valid`.
- `flush` has priority over everything except reset. At the edge it clears `out_valid` and `busy`, drops the same-cycle input beat, and returns the FSM to `IDLE`. `result` is not cleared.
- `zero` is registered with `result`.

## Timing
- Reset (`rst==0` at an edge): `out_valid=0`, `result=0`, `zero=1`, `out_rd=0`, `out_reg_write=0`, `busy=0`, FSM `IDLE`. `in_ready=0` while `rst==0`.
- Non-MUL latency: accept at edge T, result visible in the cycle after T. Throughput 1/cycle.
- MUL latency (WIDTH=32): accept at edge T, result visible after edge T+3. `in_ready=0` and `busy=1` for cycles T+1..T+3.
- A stall during MUL delays only the final load. Iterations already done are not repeated.
- Flush and stall in the same cycle: flush wins.

## Structure
- Package `ex_pkg`: `localparam` op-code constants (shared with `ALU_Ctrl`), FSM state enum, `MUL_SLICES = WIDTH/8`.
- Sub-module `iter_mul`: handles the slice accumulate and `cnt` for MUL. The ALU datapath and EX/MEM register stay in `ex_stage`.

## Test plan
- Reset then ADD `5+7` with `rd=3`, `reg_write=1` -> one cycle later `out_valid=1`, `result=12`, `zero=0`, `out_rd=3`, `out_reg_write=1`; next cycle with no input `out_valid=0`.
- SUB `9-9` -> `result=0`, `zero=1`. SUB `0-1` -> `0xFFFFFFFF`. SLT `-1 < 1` -> `result=1`.
- SLL `op_b=1`, `shamt=31` -> `0x80000000`. XOR `0xF0F0,0x0FF0` -> `0xFF00`.
- MUL `0x00012345 * 0x00000100` -> `busy=1` and `in_ready=0` for 3 cycles, then `result=0x01234500`. MUL `0xFFFFFFFF*2` -> `0xFFFFFFFE`.
- Assert `stall_in` on the last MUL slice for 2 cycles -> result loads 2 cycles late and is correct; a held valid result stays unchanged under stall.
- Assert `flush` at the 2nd MUL iteration with `in_valid=1` -> `out_valid=0` and `busy=0` next cycle, no result retires; assert `rst=0` mid-MUL -> all outputs at their reset values next cycle.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the MIPS execute stage.
//   - ALU operation codes (same encoding ALU_Ctrl emits)
//   - execute-stage FSM state type
//   - MUL slice count helpers (one 8-bit slice of op_b per iteration)
package ex_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } ex_state_e;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned MUL_SLICES    = DEFAULT_WIDTH / 8;

  // Number of 8-bit multiplier slices for a given datapath width.
  function automatic int unsigned mul_slices(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/ex_stage_iter_mul.sv
// iter_mul: iterative slice multiplier used by ex_stage for MUL.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   start_i       load operands; accumulator gets a*b[7:0], count starts at 1
//   advance_i     add the current slice term and step the count
//   a_i, b_i      operands captured on start_i
//   last_o        count is on the final slice
//   prod_o        accumulator plus the current slice term; on the final
//                 slice this is the complete low-WIDTH product
module iter_mul
  import ex_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             advance_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] prod_o
);

  localparam int unsigned SLICES = mul_slices(WIDTH);
  localparam int unsigned CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       slice_s;
  logic [WIDTH-1:0] term_s;

  assign slice_s = b_q[{cnt_q, 3'b000} +: 8];
  // Partial product truncated to WIDTH bits: modulo-2^WIDTH wrap falls out naturally.
  assign term_s  = (a_q * {{(WIDTH-8){1'b0}}, slice_s}) << {cnt_q, 3'b000};
  assign prod_o  = acc_q + term_s;
  assign last_o  = (cnt_q == LAST);

  // Operand capture and slice accumulation; the final slice is never folded
  // into acc_q, so holding on the last slice cannot add it twice.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (start_i) begin
      a_d   = a_i;
      b_d   = b_i;
      acc_d = a_i * {{(WIDTH-8){1'b0}}, b_i[7:0]};
      cnt_d = CW'(1);
    end else if (advance_i) begin
      acc_d = prod_o;
      cnt_d = cnt_q + CW'(1);
    end else begin
      acc_d = acc_q;
    end
  end

  // Multiplier state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q   <= {WIDTH{1'b0}};
      b_q   <= {WIDTH{1'b0}};
      acc_q <= {WIDTH{1'b0}};
      cnt_q <= {CW{1'b0}};
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the pipelined MIPS datapath.
// Single-cycle ALU ops load the EX/MEM register on acceptance; MUL runs
// iteratively in iter_mul and back-pressures issue until it retires.
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   in_valid / in_ready       ID/EX handshake
//   operation, op_a, op_b,
//   shamt, rd, reg_write      ID/EX beat contents
//   stall_in                  MEM cannot take a result: hold EX/MEM
//   flush                     kill in-flight work and the same-cycle beat
//   out_valid, result, zero,
//   out_rd, out_reg_write     EX/MEM register
//   busy                      MUL iteration in progress
module ex_stage
  import ex_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [4:0]       shamt,
  input  logic [4:0]       rd,
  input  logic             reg_write,
  input  logic             stall_in,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [4:0]       out_rd,
  output logic             out_reg_write,
  output logic             busy
);

  ex_state_e        state_q, state_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [4:0]       rd_q, rd_d;
  logic             rw_q, rw_d;
  logic [4:0]       mul_rd_q, mul_rd_d;
  logic             mul_rw_q, mul_rw_d;

  logic             accept_s;
  logic             mul_start_s;
  logic             mul_adv_s;
  logic             mul_last_s;
  logic [WIDTH-1:0] mul_prod_s;
  logic [WIDTH-1:0] alu_s;

  assign in_ready    = rst & (state_q == ST_IDLE) & ~stall_in;
  assign accept_s    = in_valid & in_ready & ~flush;
  assign mul_start_s = accept_s & (operation == OP_MUL);
  // Earlier slices keep iterating under stall; only the final load waits.
  assign mul_adv_s   = (state_q == ST_MUL) & ~mul_last_s & ~flush;

  iter_mul #(.WIDTH(WIDTH)) u_iter_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mul_start_s),
    .advance_i (mul_adv_s),
    .a_i       (op_a),
    .b_i       (op_b),
    .last_o    (mul_last_s),
    .prod_o    (mul_prod_s)
  );

  // Single-cycle ALU datapath.
  always_comb begin
    alu_s = {WIDTH{1'b0}};
    case (operation)
      OP_AND:  alu_s = op_a & op_b;
      OP_OR:   alu_s = op_a | op_b;
      OP_ADD:  alu_s = op_a + op_b;
      OP_SUB:  alu_s = op_a - op_b;
      OP_SLT:  alu_s = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_NOR:  alu_s = ~(op_a | op_b);
      OP_XOR:  alu_s = op_a ^ op_b;
      OP_SLL:  alu_s = op_b << shamt;
      OP_SRL:  alu_s = op_b >> shamt;
      default: alu_s = {WIDTH{1'b0}};
    endcase
  end

  // FSM next state and EX/MEM register next-state; flush outranks stall.
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    result_d = result_q;
    rd_d     = rd_q;
    rw_d     = rw_q;
    mul_rd_d = mul_rd_q;
    mul_rw_d = mul_rw_q;
    if (flush) begin
      valid_d = 1'b0;
      state_d = ST_IDLE;
    end else if (stall_in) begin
      valid_d = valid_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          valid_d = 1'b0;
          if (mul_start_s) begin
            mul_rd_d = rd;
            mul_rw_d = reg_write;
            state_d  = ST_MUL;
          end else if (accept_s) begin
            valid_d  = 1'b1;
            result_d = alu_s;
            rd_d     = rd;
            rw_d     = reg_write;
          end else begin
            valid_d = 1'b0;
          end
        end
        ST_MUL: begin
          valid_d = 1'b0;
          if (mul_last_s) begin
            valid_d  = 1'b1;
            result_d = mul_prod_s;
            rd_d     = mul_rd_q;
            rw_d     = mul_rw_q;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_MUL;
          end
        end
        default: begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end
    zero_d = (result_d == {WIDTH{1'b0}});
  end

  // FSM state and EX/MEM register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      result_q <= {WIDTH{1'b0}};
      zero_q   <= 1'b1;
      rd_q     <= 5'd0;
      rw_q     <= 1'b0;
      mul_rd_q <= 5'd0;
      mul_rw_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      rd_q     <= rd_d;
      rw_q     <= rw_d;
      mul_rd_q <= mul_rd_d;
      mul_rw_q <= mul_rw_d;
    end
  end

  assign out_valid     = valid_q;
  assign result        = result_q;
  assign zero          = zero_q;
  assign out_rd        = rd_q;
  assign out_reg_write = rw_q;
  assign busy          = (state_q == ST_MUL);

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed, table-driven bench for ex_stage (WIDTH=32).
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  operation;
  logic [31:0] op_a, op_b;
  logic [4:0]  shamt, rd;
  logic        reg_write;
  logic        stall_in;
  logic        flush;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex_stage #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .operation     (operation),
    .op_a          (op_a),
    .op_b          (op_b),
    .shamt         (shamt),
    .rd            (rd),
    .reg_write     (reg_write),
    .stall_in      (stall_in),
    .flush         (flush),
    .out_valid     (out_valid),
    .result        (result),
    .zero          (zero),
    .out_rd        (out_rd),
    .out_reg_write (out_reg_write),
    .busy          (busy)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    operation = 4'b0000;
    op_a      = 32'd0;
    op_b      = 32'd0;
    shamt     = 5'd0;
    rd        = 5'd0;
    reg_write = 1'b0;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [4:0] r, input logic rw);
    in_valid  = 1'b1;
    operation = op;
    op_a      = a;
    op_b      = b;
    shamt     = sh;
    rd        = r;
    reg_write = rw;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] res,
                           input logic [4:0] r, input logic rw);
    check({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, v});
    check({tag, " result"}, result, res);
    check({tag, " zero"}, {31'd0, zero}, {31'd0, (res == 32'd0)});
    check({tag, " out_rd"}, {27'd0, out_rd}, {27'd0, r});
    check({tag, " out_reg_write"}, {31'd0, out_reg_write}, {31'd0, rw});
  endtask

  initial begin
    vecs[0]  = '{4'b0010, 32'd5,          32'd7,          5'd0,  5'd3,  1'b1, 32'd12};
    vecs[1]  = '{4'b0110, 32'd9,          32'd9,          5'd0,  5'd4,  1'b1, 32'd0};
    vecs[2]  = '{4'b0110, 32'd0,          32'd1,          5'd0,  5'd5,  1'b0, 32'hFFFF_FFFF};
    vecs[3]  = '{4'b0111, 32'hFFFF_FFFF,  32'd1,          5'd0,  5'd6,  1'b1, 32'd1};
    vecs[4]  = '{4'b0111, 32'd1,          32'hFFFF_FFFF,  5'd0,  5'd7,  1'b1, 32'd0};
    vecs[5]  = '{4'b0100, 32'd0,          32'd1,          5'd31, 5'd8,  1'b1, 32'h8000_0000};
    vecs[6]  = '{4'b0101, 32'd0,          32'h8000_0000,  5'd4,  5'd9,  1'b1, 32'h0800_0000};
    vecs[7]  = '{4'b0011, 32'h0000_F0F0,  32'h0000_0FF0,  5'd0,  5'd10, 1'b1, 32'h0000_FF00};
    vecs[8]  = '{4'b0000, 32'h0000_F0F0,  32'h0000_0FF0,  5'd0,  5'd11, 1'b1, 32'h0000_00F0};
    vecs[9]  = '{4'b0001, 32'h0000_F0F0,  32'h0000_0FF0,  5'd0,  5'd12, 1'b0, 32'h0000_FFF0};
    vecs[10] = '{4'b1100, 32'h0000_F0F0,  32'h0000_0FF0,  5'd0,  5'd13, 1'b1, 32'hFFFF_000F};
    vecs[11] = '{4'b1100, 32'd0,          32'd0,          5'd0,  5'd14, 1'b1, 32'hFFFF_FFFF};
    vecs[12] = '{4'b0010, 32'hFFFF_FFFF,  32'd1,          5'd0,  5'd15, 1'b1, 32'd0};
    vecs[13] = '{4'b1111, 32'd123,        32'd456,        5'd3,  5'd16, 1'b1, 32'd0};
    vecs[14] = '{4'b0101, 32'd0,          32'hF000_0000,  5'd31, 5'd31, 1'b1, 32'd1};

    rst      = 1'b0;
    stall_in = 1'b0;
    flush    = 1'b0;
    idle_inputs();
    tick();
    tick();
    // Reset state
    check_out("reset", 1'b0, 32'd0, 5'd0, 1'b0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("post-reset in_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back single-cycle ops
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].rd, vecs[i].rw);
      tick();
      check_out($sformatf("vec%0d", i), 1'b1, vecs[i].exp, vecs[i].rd, vecs[i].rw);
    end
    // Bubble: valid drops, other fields keep their values
    idle_inputs();
    tick();
    check_out("bubble", 1'b0, vecs[NV-1].exp, vecs[NV-1].rd, vecs[NV-1].rw);

    // MUL 0x00012345 * 0x100: busy for 3 cycles, then result
    drive(4'b1000, 32'h0001_2345, 32'h0000_0100, 5'd0, 5'd20, 1'b1);
    tick();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("mul1 busy c%0d", k), {31'd0, busy}, 32'd1);
      check($sformatf("mul1 in_ready c%0d", k), {31'd0, in_ready}, 32'd0);
      check($sformatf("mul1 out_valid c%0d", k), {31'd0, out_valid}, 32'd0);
      tick();
    end
    check_out("mul1", 1'b1, 32'h0123_4500, 5'd20, 1'b1);
    check("mul1 done busy", {31'd0, busy}, 32'd0);

    // MUL 0xFFFFFFFF * 2 wraps
    drive(4'b1000, 32'hFFFF_FFFF, 32'd2, 5'd0, 5'd9, 1'b0);
    tick();
    idle_inputs();
    tick(); tick(); tick();
    check_out("mul2", 1'b1, 32'hFFFF_FFFE, 5'd9, 1'b0);

    // Stall on the last MUL slice for 2 cycles
    drive(4'b1000, 32'd3, 32'h0102_0304, 5'd0, 5'd21, 1'b1);
    tick();
    idle_inputs();
    tick(); tick();
    stall_in = 1'b1;
    tick();
    check("stall c0 out_valid", {31'd0, out_valid}, 32'd0);
    check("stall c0 busy", {31'd0, busy}, 32'd1);
    tick();
    check("stall c1 out_valid", {31'd0, out_valid}, 32'd0);
    check("stall c1 busy", {31'd0, busy}, 32'd1);
    stall_in = 1'b0;
    tick();
    check_out("stall mul", 1'b1, 32'h0306_090C, 5'd21, 1'b1);
    // Held valid result under stall
    stall_in = 1'b1;
    tick();
    check_out("hold c0", 1'b1, 32'h0306_090C, 5'd21, 1'b1);
    tick();
    check_out("hold c1", 1'b1, 32'h0306_090C, 5'd21, 1'b1);
    stall_in = 1'b0;
    tick();
    check("hold release out_valid", {31'd0, out_valid}, 32'd0);

    // Flush at the 2nd MUL iteration with a new beat present
    drive(4'b1000, 32'd5, 32'd7, 5'd0, 5'd22, 1'b1);
    tick();
    drive(4'b0010, 32'd1, 32'd1, 5'd0, 5'd23, 1'b1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle_inputs();
    check("flush out_valid", {31'd0, out_valid}, 32'd0);
    check("flush busy", {31'd0, busy}, 32'd0);
    check("flush in_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("flush no-retire c%0d", k), {31'd0, out_valid}, 32'd0);
    end
    check("flush result kept", result, 32'h0306_090C);

    // Flush in IDLE drops the same-cycle beat
    drive(4'b0010, 32'd1, 32'd1, 5'd0, 5'd24, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle_inputs();
    check("idle flush out_valid", {31'd0, out_valid}, 32'd0);
    check("idle flush result", result, 32'h0306_090C);

    // Reset mid-MUL
    drive(4'b1000, 32'd6, 32'd6, 5'd0, 5'd25, 1'b1);
    tick();
    idle_inputs();
    tick();
    rst = 1'b0;
    tick();
    check_out("mid reset", 1'b0, 32'd0, 5'd0, 1'b0);
    check("mid reset busy", {31'd0, busy}, 32'd0);
    check("mid reset in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("after reset in_ready", {31'd0, in_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
